// File: rtl/response_router.sv
// rtl/response_router.sv - routes shared-resource responses back to the issuing pipeline
// Per-ID ownership table, per-port response FIFOs and credit stall toward the arbiter.
module response_router #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_issue_valid,
  input  logic              in_issue_choice,
  input  logic [ID_W-1:0]   in_issue_id,
  input  logic              in_flush_1,
  input  logic              in_flush_2,
  input  logic [ID_W-1:0]   in_flush_id_1,
  input  logic [ID_W-1:0]   in_flush_id_2,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_valid,
  input  logic              in_ready_1,
  input  logic              in_ready_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [ID_W-1:0]   out_id_1,
  output logic [ID_W-1:0]   out_id_2,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic              out_credit_stall_1,
  output logic              out_credit_stall_2,
  output logic [2:0]        out_err
);
  localparam int N_ID = 1 << ID_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OW   = ID_W + 1;
  localparam int SW   = ((OW > CW) ? OW : CW) + 1;
  localparam int EW   = DATA_W + ID_W;

  logic [N_ID-1:0] r_pending, r_owner, r_cancel;
  logic [EW-1:0]   r_mem [2][DEPTH];
  logic [PW-1:0]   r_wptr [2];
  logic [PW-1:0]   r_rptr [2];
  logic [CW-1:0]   r_count [2];
  logic [OW-1:0]   r_outst [2];
  logic [2:0]      r_err;

  logic [1:0]      w_flush, w_ready, w_flush_hit, w_push, w_pop, w_full, w_acc, w_ovf, w_inc, w_dec;
  logic [1:0]      w_flush_same, w_stall, w_valid;
  logic [ID_W-1:0] w_flush_id [2];
  logic [EW-1:0]   w_head [2];
  logic            w_rsp_hit, w_rsp_own, w_rsp_flushed, w_dup, w_orphan;

  assign w_flush       = {in_flush_2, in_flush_1};
  assign w_ready       = {in_ready_2, in_ready_1};
  assign w_flush_id[0] = in_flush_id_1;
  assign w_flush_id[1] = in_flush_id_2;

  assign w_rsp_hit     = in_valid & r_pending[in_id];
  assign w_rsp_own     = r_owner[in_id];
  assign w_orphan      = in_valid & ~r_pending[in_id];
  assign w_rsp_flushed = |w_flush_same;
  // A re-issue on the ID that is retiring this cycle is a fresh transaction, not a duplicate.
  assign w_dup = in_issue_valid & r_pending[in_issue_id] & ~(w_rsp_hit & (in_id == in_issue_id));

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign w_flush_hit[g]  = w_flush[g] & r_pending[w_flush_id[g]] & (r_owner[w_flush_id[g]] == 1'(g));
    assign w_flush_same[g] = w_flush_hit[g] & (w_flush_id[g] == in_id);
    assign w_push[g]  = w_rsp_hit & ~r_cancel[in_id] & ~w_rsp_flushed & (w_rsp_own == 1'(g));
    assign w_valid[g] = (r_count[g] != '0);
    assign w_pop[g]   = w_valid[g] & w_ready[g];
    assign w_full[g]  = (r_count[g] == CW'(DEPTH));
    assign w_ovf[g]   = w_push[g] & w_full[g] & ~w_pop[g];
    assign w_acc[g]   = w_push[g] & ~w_ovf[g];
    assign w_inc[g]   = in_issue_valid & (in_issue_choice == 1'(g));
    assign w_dec[g]   = w_rsp_hit & (w_rsp_own == 1'(g));
    assign w_head[g]  = w_valid[g] ? r_mem[g][r_rptr[g]] : '0;
    assign w_stall[g] = (SW'(r_count[g]) + SW'(r_outst[g])) >= SW'(DEPTH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_owner   <= '0;
      r_cancel  <= '0;
      r_err     <= '0;
      for (int n = 0; n < 2; n++) begin
        r_wptr[n]  <= '0;
        r_rptr[n]  <= '0;
        r_count[n] <= '0;
        r_outst[n] <= '0;
      end
    end else begin
      // Later assignments win: response retire, then flush, then issue.
      if (w_rsp_hit) r_pending[in_id] <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (w_flush_hit[n] && !(w_rsp_hit && (w_flush_id[n] == in_id)))
          r_cancel[w_flush_id[n]] <= 1'b1;
      end
      if (in_issue_valid) begin
        r_pending[in_issue_id] <= 1'b1;
        r_owner[in_issue_id]   <= in_issue_choice;
        r_cancel[in_issue_id]  <= 1'b0;
      end
      r_err <= r_err | {|w_ovf, w_dup, w_orphan};
      for (int n = 0; n < 2; n++) begin
        if (w_acc[n]) begin
          r_mem[n][r_wptr[n]] <= {in_data, in_id};
          r_wptr[n]           <= r_wptr[n] + 1'b1;
        end
        if (w_pop[n]) r_rptr[n] <= r_rptr[n] + 1'b1;
        r_count[n] <= r_count[n] + CW'(w_acc[n]) - CW'(w_pop[n]);
        r_outst[n] <= r_outst[n] + OW'(w_inc[n]) - OW'(w_dec[n]);
      end
    end
  end

  assign out_valid_1        = w_valid[0];
  assign out_valid_2        = w_valid[1];
  assign out_data_1         = w_head[0][EW-1:ID_W];
  assign out_data_2         = w_head[1][EW-1:ID_W];
  assign out_id_1           = w_head[0][ID_W-1:0];
  assign out_id_2           = w_head[1][ID_W-1:0];
  assign out_credit_stall_1 = w_stall[0];
  assign out_credit_stall_2 = w_stall[1];
  assign out_err            = r_err;
endmodule

// File: tb/tb_response_router.sv
// tb/tb_response_router.sv - directed checks for response_router
module tb_response_router;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_issue_valid, in_issue_choice;
  logic [2:0] in_issue_id;
  logic       in_flush_1, in_flush_2;
  logic [2:0] in_flush_id_1, in_flush_id_2;
  logic [7:0] in_data;
  logic [2:0] in_id;
  logic       in_valid, in_ready_1, in_ready_2;
  logic [7:0] out_data_1, out_data_2;
  logic [2:0] out_id_1, out_id_2;
  logic       out_valid_1, out_valid_2, out_credit_stall_1, out_credit_stall_2;
  logic [2:0] out_err;

  int n_tests = 0;
  int n_fail  = 0;

  response_router #(.DATA_W(8), .ID_W(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_issue_valid(in_issue_valid), .in_issue_choice(in_issue_choice), .in_issue_id(in_issue_id),
    .in_flush_1(in_flush_1), .in_flush_2(in_flush_2),
    .in_flush_id_1(in_flush_id_1), .in_flush_id_2(in_flush_id_2),
    .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
    .in_ready_1(in_ready_1), .in_ready_2(in_ready_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_id_1(out_id_1), .out_id_2(out_id_2),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_credit_stall_1(out_credit_stall_1), .out_credit_stall_2(out_credit_stall_2),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_issue_valid = 1'b0;
    in_flush_1     = 1'b0;
    in_flush_2     = 1'b0;
    in_valid       = 1'b0;
  endtask

  task automatic issue(input logic [2:0] id, input logic choice);
    in_issue_valid  = 1'b1;
    in_issue_id     = id;
    in_issue_choice = choice;
  endtask

  task automatic respond(input logic [2:0] id, input logic [7:0] data);
    in_valid = 1'b1;
    in_id    = id;
    in_data  = data;
  endtask

  initial begin
    reset = 1'b0;
    in_issue_valid = 0; in_issue_choice = 0; in_issue_id = 0;
    in_flush_1 = 0; in_flush_2 = 0; in_flush_id_1 = 0; in_flush_id_2 = 0;
    in_data = 0; in_id = 0; in_valid = 0; in_ready_1 = 0; in_ready_2 = 0;
    tick(); tick();
    check("rst_valid_1", out_valid_1, 0);
    check("rst_valid_2", out_valid_2, 0);
    check("rst_data_1", out_data_1, 0);
    check("rst_stall_1", out_credit_stall_1, 0);
    check("rst_stall_2", out_credit_stall_2, 0);
    check("rst_err", out_err, 0);
    reset = 1'b1;
    tick();

    // basic route to pipeline 1
    issue(3, 0); tick();
    tick();
    respond(3, 8'hA5); tick();
    check("t1_valid_1", out_valid_1, 1);
    check("t1_data_1", out_data_1, 8'hA5);
    check("t1_id_1", out_id_1, 3);
    check("t1_valid_2", out_valid_2, 0);
    check("t1_stall_1", out_credit_stall_1, 0);
    in_ready_1 = 1; tick(); in_ready_1 = 0;
    check("t1_popped", out_valid_1, 0);

    // flushed response on pipeline 2 is dropped
    issue(5, 1); tick();
    in_flush_2 = 1; in_flush_id_2 = 5; tick();
    respond(5, 8'h5A); tick();
    check("t2_valid_2", out_valid_2, 0);
    check("t2_stall_2", out_credit_stall_2, 0);
    check("t2_err", out_err, 0);

    // fill FIFO 1 to DEPTH; stall appears exactly at sum==4
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 0); tick();
      check("t3_stall_iss", out_credit_stall_1, (i == 3) ? 1 : 0);
      respond(3'(i), 8'h10 + 8'(i)); tick();
      check("t3_stall_rsp", out_credit_stall_1, (i == 3) ? 1 : 0);
    end
    check("t3_err", out_err, 0);
    in_ready_1 = 1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain", out_data_1, 8'h10 + 8'(i));
      tick();
    end
    in_ready_1 = 0;
    check("t3_empty", out_valid_1, 0);
    check("t3_stall_end", out_credit_stall_1, 0);

    // same-cycle response + re-issue on id 4 (pipeline 2)
    issue(4, 1); tick();
    issue(4, 1); respond(4, 8'h44); tick();
    check("t5_valid_2", out_valid_2, 1);
    check("t5_data_2", out_data_2, 8'h44);
    check("t5_id_2", out_id_2, 4);
    check("t5_err", out_err, 0);
    respond(4, 8'h55); tick();
    check("t5_err_pend", out_err, 0);
    in_ready_2 = 1;
    check("t5_drain0", out_data_2, 8'h44); tick();
    check("t5_drain1", out_data_2, 8'h55); tick();
    in_ready_2 = 0;
    check("t5_empty", out_valid_2, 0);

    // orphan and duplicate issue
    respond(7, 8'h77); tick();
    check("t4_valid_1", out_valid_1, 0);
    check("t4_valid_2", out_valid_2, 0);
    check("t4_orphan", out_err, 3'b001);
    issue(2, 0); tick();
    issue(2, 0); tick();
    check("t4_dup", out_err, 3'b011);
    respond(2, 8'h22); tick();
    in_ready_1 = 1; tick(); in_ready_1 = 0;

    // overflow on FIFO 2, then push accepted when full with a pop
    for (int i = 0; i < 5; i++) begin
      issue(3'(i), 1); tick();
      respond(3'(i), 8'h60 + 8'(i)); tick();
    end
    check("t6_ovf", out_err, 3'b111);
    check("t6_head", out_data_2, 8'h60);
    issue(5, 1); tick();
    in_ready_2 = 1; respond(5, 8'h6A); tick();
    check("t6_d1", out_data_2, 8'h61); tick();
    check("t6_d2", out_data_2, 8'h62); tick();
    check("t6_d3", out_data_2, 8'h63); tick();
    check("t6_d4", out_data_2, 8'h6A); tick();
    in_ready_2 = 0;
    check("t6_empty", out_valid_2, 0);
    check("t6_stall_2", out_credit_stall_2, 0);

    // reset mid-operation
    issue(1, 0); tick();
    respond(1, 8'h11); tick();
    issue(2, 0); tick();
    respond(2, 8'h12); tick();
    issue(6, 0); tick();
    check("t7_pre_valid", out_valid_1, 1);
    reset = 1'b0;
    #1;
    check("t7_valid_1", out_valid_1, 0);
    check("t7_data_1", out_data_1, 0);
    check("t7_stall_1", out_credit_stall_1, 0);
    check("t7_err", out_err, 0);
    tick();
    reset = 1'b1;
    tick();
    respond(6, 8'h66); tick();
    check("t7_late_valid", out_valid_1, 0);
    check("t7_late_err", out_err, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
